// File: rtl/riscv_sb_pkg.sv
// Shared definitions for the store write buffer.
// Provides:
//   SB_DEPTH     default number of buffered stores
//   SB_ADDR_W    default address width
//   SB_DATA_W    default store data width
//   SB_WORD_LSB  lowest address bit of the word address
//   sb_entry_t   one buffered store {addr, data} at the default widths
package riscv_sb_pkg;

  localparam int unsigned SB_DEPTH    = 4;
  localparam int unsigned SB_ADDR_W   = 32;
  localparam int unsigned SB_DATA_W   = 32;
  localparam int unsigned SB_WORD_LSB = 2;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo_ctrl.sv
// Pointer/occupancy control for the store write buffer FIFO.
// Owns wr_ptr, rd_ptr, count, full and empty, and arbitrates enqueue/dequeue.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   memwrite_i        core store request
//   mem_req_ready_i   memory accepts the head entry
//   wr_ptr_o/rd_ptr_o write / read pointers (wrap modulo DEPTH)
//   count_o           occupancy 0..DEPTH
//   empty_o           no entries pending
//   enq_o/deq_o       enqueue / dequeue strobes for this cycle
//   stall_o           store not accepted this cycle (combinational)
module sb_fifo_ctrl
  import riscv_sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memwrite_i,
  input  logic             mem_req_ready_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             enq_o,
  output logic             deq_o,
  output logic             stall_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;

  // Handshake arbitration; a dequeue frees a slot for a same-cycle enqueue.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign deq   = !empty && mem_req_ready_i;
  assign enq   = memwrite_i && (!full || deq);

  // Next-state pointers and occupancy; pointer wrap relies on power-of-two DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign empty_o  = empty;
  assign enq_o    = enq;
  assign deq_o    = deq;
  assign stall_o  = memwrite_i && full && !deq;

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store buffer between the core data-memory write port and memory.
// Absorbs stores into a DEPTH-entry FIFO, drains one per valid/ready handshake,
// stalls the core when full, and forwards the youngest pending store to loads.
// Optional feature macro: STORE_FWD_EN (forwarding comparators built when defined;
// otherwise fwd_hit/fwd_data are tied to 0 and rd_adr is ignored).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   memwrite, dataadr, writedata core store request
//   stall                       store not accepted this cycle
//   rd_adr, fwd_hit, fwd_data   load address and forwarding result
//   mem_req_valid/ready         memory request handshake
//   mem_addr, mem_wdata         head entry presented to memory
//   empty                       no stores pending
module store_write_buffer
  import riscv_sb_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              stall,
  input  logic [ADDR_W-1:0] rd_adr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              enq;
  logic              deq;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  sb_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk             (clk),
    .rst             (rst),
    .memwrite_i      (memwrite),
    .mem_req_ready_i (mem_req_ready),
    .wr_ptr_o        (wr_ptr),
    .rd_ptr_o        (rd_ptr),
    .count_o         (count),
    .empty_o         (empty),
    .enq_o           (enq),
    .deq_o           (deq),
    .stall_o         (stall)
  );

  // Entry storage; reset clears every slot so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (enq) begin
      addr_q[wr_ptr] <= dataadr;
      data_q[wr_ptr] <= writedata;
    end
  end

  // Head entry stays put until dequeued, so it is stable while ready is low.
  assign mem_req_valid = !empty;
  assign mem_addr      = addr_q[rd_ptr];
  assign mem_wdata     = data_q[rd_ptr];

`ifdef STORE_FWD_EN
  logic unused_rd_lsb;
  assign unused_rd_lsb = ^{rd_adr[SB_WORD_LSB-1:0], deq};

  // Walk entries oldest to youngest so the last (youngest) match wins.
  // A store being enqueued this cycle is not yet in storage, so it never forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) &&
          (addr_q[rd_ptr + PTR_W'(i)][ADDR_W-1:SB_WORD_LSB] ==
           rd_adr[ADDR_W-1:SB_WORD_LSB])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[rd_ptr + PTR_W'(i)];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rd_adr, count, deq};

  // Without forwarding the core stalls loads while the buffer is not empty.
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed vector table followed by
// randomized traffic compared against a queue-based reference model.
module tb_store_write_buffer;
  import riscv_sb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          stall;
  logic [AW-1:0] rd_adr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          empty;

  always #5 clk = ~clk;

  store_write_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .memwrite      (memwrite),
    .dataadr       (dataadr),
    .writedata     (writedata),
    .stall         (stall),
    .rd_adr        (rd_adr),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .empty         (empty)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic          rst;
    logic          mw;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
    logic          rdy;
    logic [AW-1:0] rda;
    logic          e_stall;
    logic          e_valid;
    logic          e_empty;
    logic          chk_head;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_hit;
    logic [DW-1:0] e_fdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic mw, input int adr, input int wd,
                     input logic rdy, input int rda,
                     input logic e_stall, input logic e_valid, input logic e_empty,
                     input logic chk_head, input int e_addr, input int e_wdata,
                     input logic e_hit, input int e_fdata);
    vec_t v;
    v.rst = r; v.mw = mw; v.adr = AW'(adr); v.wd = DW'(wd); v.rdy = rdy; v.rda = AW'(rda);
    v.e_stall = e_stall; v.e_valid = e_valid; v.e_empty = e_empty;
    v.chk_head = chk_head; v.e_addr = AW'(e_addr); v.e_wdata = DW'(e_wdata);
    v.e_hit = e_hit & FWD;
    v.e_fdata = FWD ? DW'(e_fdata) : '0;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic mw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rdy, input logic [AW-1:0] ra);
    rst = r; memwrite = mw; dataadr = a; writedata = d; mem_req_ready = rdy; rd_adr = ra;
  endtask

  sb_entry_t q[$];

  initial begin
    logic          r, mw, rdy, e_empty, e_valid, deq, full, e_stall, e_hit;
    logic [AW-1:0] a, ra;
    logic [DW-1:0] d, e_fd;
    sb_entry_t     ent;

    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;

    //   rst mw adr  wd  rdy rda | stall valid empty chk addr wd hit fdata
    add(0, 0,   0,  0, 1,   0,   0, 0, 1, 1,   0,  0, 0, 0); // reset state
    add(0, 1, 100, 25, 1, 100,   0, 0, 1, 0,   0,  0, 0, 0); // single store, same-cycle not fwd
    add(0, 0,   0,  0, 1, 100,   0, 1, 0, 1, 100, 25, 1, 25); // head forwards in deq cycle
    add(0, 0,   0,  0, 0,   0,   0, 0, 1, 0,   0,  0, 0, 0); // drained
    add(0, 1,  80,  1, 0,   0,   0, 0, 1, 0,   0,  0, 0, 0); // fill
    add(0, 1,  84,  2, 0,  80,   0, 1, 0, 1,  80,  1, 1, 1);
    add(0, 1,  88,  3, 0,   0,   0, 1, 0, 1,  80,  1, 0, 0);
    add(0, 1,  92,  4, 0,   0,   0, 1, 0, 1,  80,  1, 0, 0);
    add(0, 1,  96,  5, 0,   0,   1, 1, 0, 1,  80,  1, 0, 0); // full -> stall
    add(0, 1,  96,  5, 0,   0,   1, 1, 0, 1,  80,  1, 0, 0); // still stalled, head held
    add(0, 1,  96,  5, 1,   0,   0, 1, 0, 1,  80,  1, 0, 0); // accepted on deq
    add(0, 1, 100,  6, 1,   0,   0, 1, 0, 1,  84,  2, 0, 0); // full enq+deq
    add(0, 0,   0,  0, 0,  98,   0, 1, 0, 1,  88,  3, 1, 5);
    add(0, 0,   0,  0, 1,   0,   0, 1, 0, 1,  88,  3, 0, 0); // drain in order
    add(0, 0,   0,  0, 1,   0,   0, 1, 0, 1,  92,  4, 0, 0);
    add(0, 0,   0,  0, 1,   0,   0, 1, 0, 1,  96,  5, 0, 0);
    add(0, 0,   0,  0, 1,   0,   0, 1, 0, 1, 100,  6, 0, 0);
    add(0, 0,   0,  0, 0,   0,   0, 0, 1, 0,   0,  0, 0, 0);
    add(0, 1,  96,  7, 0,  98,   0, 0, 1, 0,   0,  0, 0, 0); // forwarding priority
    add(0, 1,  96,  9, 0,  98,   0, 1, 0, 1,  96,  7, 1, 7);
    add(0, 0,   0,  0, 0,  98,   0, 1, 0, 1,  96,  7, 1, 9);
    add(0, 0,   0,  0, 0, 100,   0, 1, 0, 1,  96,  7, 0, 0);
    add(0, 1, 200, 11, 0,  96,   0, 1, 0, 1,  96,  7, 1, 9);
    add(1, 1, 300, 12, 1,   0,   0, 1, 0, 1,  96,  7, 0, 0); // reset wins over enq/deq
    add(0, 0,   0,  0, 1,  96,   0, 0, 1, 1,   0,  0, 0, 0);
    add(0, 0,   0,  0, 1, 300,   0, 0, 1, 1,   0,  0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].mw, vecs[i].adr, vecs[i].wd, vecs[i].rdy, vecs[i].rda);
      @(negedge clk);
      chk($sformatf("v%0d stall", i), 64'(stall), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d valid", i), 64'(mem_req_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d empty", i), 64'(empty), 64'(vecs[i].e_empty));
      chk($sformatf("v%0d fwd_hit", i), 64'(fwd_hit), 64'(vecs[i].e_hit));
      if (!FWD || vecs[i].e_hit)
        chk($sformatf("v%0d fwd_data", i), 64'(fwd_data), 64'(vecs[i].e_fdata));
      if (vecs[i].chk_head) begin
        chk($sformatf("v%0d mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_addr));
        chk($sformatf("v%0d mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].e_wdata));
      end
      @(posedge clk);
      #1;
    end

    // Randomized phase against the queue model.
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 99) == 0);
      mw  = ($urandom_range(0, 2) != 0);
      rdy = 1'($urandom_range(0, 1));
      a   = AW'($urandom_range(0, 31));
      d   = DW'($urandom);
      ra  = AW'($urandom_range(0, 31));
      drive(r, mw, a, d, rdy, ra);
      @(negedge clk);
      e_empty = (q.size() == 0);
      e_valid = !e_empty;
      deq     = e_valid && rdy;
      full    = (q.size() == DEPTH);
      e_stall = mw && full && !deq;
      e_hit   = 1'b0;
      e_fd    = '0;
      if (FWD) begin
        for (int k = int'(q.size()) - 1; k >= 0; k--) begin
          if (q[k].addr[AW-1:2] == ra[AW-1:2]) begin
            e_hit = 1'b1;
            e_fd  = q[k].data;
            break;
          end
        end
      end
      chk($sformatf("r%0d stall", c), 64'(stall), 64'(e_stall));
      chk($sformatf("r%0d valid", c), 64'(mem_req_valid), 64'(e_valid));
      chk($sformatf("r%0d empty", c), 64'(empty), 64'(e_empty));
      chk($sformatf("r%0d fwd_hit", c), 64'(fwd_hit), 64'(e_hit));
      if (!FWD || e_hit)
        chk($sformatf("r%0d fwd_data", c), 64'(fwd_data), 64'(e_fd));
      if (e_valid) begin
        chk($sformatf("r%0d mem_addr", c), 64'(mem_addr), 64'(q[0].addr));
        chk($sformatf("r%0d mem_wdata", c), 64'(mem_wdata), 64'(q[0].data));
      end
      if (r) begin
        q.delete();
      end else begin
        if (deq) void'(q.pop_front());
        if (mw && (!full || deq)) begin
          ent.addr = a;
          ent.data = d;
          q.push_back(ent);
        end
      end
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
